// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scanner.
// Frame-synchronous display update, LZ blanking, per-digit enable.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              outSeg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);

  localparam logic [PW-1:0] P_LAST =
    PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST =
    IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    wrap;
  logic                    wrap_q;

  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_ok;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic [3:0]              nib;
  logic                    dsel;
  logic                    en_sel;
  logic                    lz_hit;
  logic                    zero_run;

  assign tick = (pcnt == P_LAST);
  assign wrap = tick && (idx == I_LAST);

  // active-low glyphs in {g,f,e,d,c,b,a} order
  function automatic logic [6:0] glyph(
    input logic [3:0] n
  );
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // prescaler and digit index; index advances once per slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // pending capture; display only changes on the frame wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_ok  <= 1'b0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else if (wrap) begin
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
      end else if (pend_ok) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      pend_ok <= 1'b0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend_ok  <= 1'b1;
    end
  end

  // select current digit; zero_run tracks all-zero nibbles from the top
  always_comb begin
    nib      = '0;
    dsel     = 1'b0;
    en_sel   = 1'b0;
    lz_hit   = 1'b0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run &&
                 (disp_val[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib    = disp_val[4*i +: 4];
        dsel   = disp_dp[i];
        en_sel = digit_en[i];
        lz_hit = zero_run && (i != 0);
      end
    end
  end

  // registered output stage; frame_done aligns with digit 0 reappearing
  always_ff @(posedge clk) begin
    if (!reset) begin
      outSeg     <= '1;
      dp         <= 1'b1;
      anode      <= '1;
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wrap_q     <= wrap;
      frame_done <= wrap_q;
      if (!en_sel) begin
        outSeg <= '1;
        dp     <= 1'b1;
        anode  <= '1;
      end else begin
        anode  <= ~(NUM_DIGITS'(1) << idx);
        outSeg <= (lz_blank && lz_hit) ?
                  7'b1111111 : glyph(nib);
        dp     <= ~dsel;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: table vectors, directed corners and
// randomized stimulus against a frame-level reference model.
module tb_seg_scan_driver;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int NR = N * R;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  outSeg;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } gvec_t;
  gvec_t gtab [16];

  // reference model state: edges since release, shown frame contents
  int          e = 0;
  logic [15:0] cur_val = '0;
  logic [3:0]  cur_dp = '0;
  logic        have_pend = 1'b0;
  int          pend_frame = 0;
  logic [15:0] pv = '0;
  logic [3:0]  pd = '0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .lz_blank  (lz_blank),
    .load      (load),
    .outSeg    (outSeg),
    .dp        (dp),
    .anode     (anode),
    .frame_done(frame_done)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               nm, act, exp, e);
    end
  endtask

  // one clock: update the model from sampled inputs, compare all outputs
  task automatic cyc();
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        edp;
    logic        efd;
    logic [15:0] nv;
    int d;
    int fr;
    ea = 4'hF; es = 7'h7F; edp = 1'b1; efd = 1'b0;
    fr = 0; d = 0;
    @(posedge clk);
    if (!reset) begin
      e = 0;
      cur_val = '0;
      cur_dp = '0;
      have_pend = 1'b0;
    end else begin
      e++;
      fr = (e - 1) / NR;
      if (have_pend && pend_frame <= fr) begin
        cur_val = pv;
        cur_dp = pd;
        have_pend = 1'b0;
      end
      if (load) begin
        pend_frame = (e + NR - 1) / NR;
        pv = value;
        pd = dp_in;
        have_pend = 1'b1;
      end
      d = ((e - 1) / R) % N;
      efd = ((e - 1) % NR == 0) && (fr >= 1);
      nv = cur_val >> (4 * d);
      if (digit_en[d]) begin
        ea = ~(4'b0001 << d);
        es = (lz_blank && d >= 1 && nv == 16'h0) ?
             7'h7F : gtab[nv[3:0]].seg;
        edp = ~cur_dp[d];
      end
    end
    #1;
    chk("cycle", {anode, outSeg, dp, frame_done},
        {ea, es, edp, efd});
  endtask

  // advance to the first output cycle of digit d's slot
  task automatic wait_slot(input int d);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (((e - 1) % NR != d * R) && n < 40);
    if ((e - 1) % NR != d * R)
      chk("slot_timeout", 32'(e), 32'(d * R + 1));
  endtask

  initial begin
    logic [3:0] seq [5];
    int n;

    gtab[0]  = '{4'h0, 7'b1000000};
    gtab[1]  = '{4'h1, 7'b1111001};
    gtab[2]  = '{4'h2, 7'b0100100};
    gtab[3]  = '{4'h3, 7'b0110000};
    gtab[4]  = '{4'h4, 7'b0011001};
    gtab[5]  = '{4'h5, 7'b0010010};
    gtab[6]  = '{4'h6, 7'b0000010};
    gtab[7]  = '{4'h7, 7'b1111000};
    gtab[8]  = '{4'h8, 7'b0000000};
    gtab[9]  = '{4'h9, 7'b0010000};
    gtab[10] = '{4'hA, 7'b0001000};
    gtab[11] = '{4'hB, 7'b0000011};
    gtab[12] = '{4'hC, 7'b1000110};
    gtab[13] = '{4'hD, 7'b0100001};
    gtab[14] = '{4'hE, 7'b0000110};
    gtab[15] = '{4'hF, 7'b0001110};
    seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    // reset state and scan order
    reset = 1'b0;
    repeat (3) cyc();
    chk("rst_seg", outSeg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_anode", anode, 4'hF);
    chk("rst_fd", frame_done, 1'b0);
    reset = 1'b1;
    cyc();
    chk("first_anode", anode, 4'hE);
    chk("first_seg", outSeg, 7'b1000000);
    for (int k = 1; k < 5; k++) begin
      repeat (R) cyc();
      chk("anode_seq", anode, seq[k]);
    end
    chk("fd_frame1", frame_done, 1'b1);
    repeat (NR) cyc();
    chk("fd_frame2", frame_done, 1'b1);

    // glyph sweep
    for (int i = 0; i < 16; i++) begin
      value = {4{gtab[i].nib}};
      load = 1'b1;
      cyc();
      load = 1'b0;
      wait_slot(0);
      chk("glyph", outSeg, gtab[i].seg);
    end

    // tear-free update, then last-load-wins
    wait_slot(1);
    value = 16'h1234;
    load = 1'b1;
    cyc();
    load = 1'b0;
    wait_slot(3);
    chk("tear_old", outSeg, 7'b0001110);
    wait_slot(0);
    chk("tear_fd", frame_done, 1'b1);
    chk("tear_d0", outSeg, 7'b0011001);
    wait_slot(3);
    chk("tear_d3", outSeg, 7'b1111001);
    wait_slot(1);
    value = 16'h1234;
    load = 1'b1;
    cyc();
    value = 16'hABCD;
    cyc();
    load = 1'b0;
    wait_slot(0);
    chk("last_d0", outSeg, 7'b0100001);
    wait_slot(3);
    chk("last_d3", outSeg, 7'b0001000);

    // leading-zero blanking
    lz_blank = 1'b1;
    value = 16'h0050;
    dp_in = 4'b1000;
    load = 1'b1;
    cyc();
    load = 1'b0;
    dp_in = 4'b0000;
    wait_slot(0);
    chk("lz_d0", {outSeg, dp}, {7'b1000000, 1'b1});
    wait_slot(1);
    chk("lz_d1", {outSeg, dp}, {7'b0010010, 1'b1});
    wait_slot(2);
    chk("lz_d2", {outSeg, dp}, {7'b1111111, 1'b1});
    wait_slot(3);
    chk("lz_d3", {outSeg, dp}, {7'b1111111, 1'b0});
    value = 16'h0000;
    load = 1'b1;
    cyc();
    load = 1'b0;
    wait_slot(0);
    chk("lz_zero_d0", outSeg, 7'b1000000);

    // per-digit enable
    digit_en = 4'b0101;
    wait_slot(1);
    chk("en_d1", {anode, outSeg, dp},
        {4'hF, 7'h7F, 1'b1});
    wait_slot(2);
    chk("en_d2", anode, 4'hB);
    wait_slot(3);
    chk("en_d3", {anode, outSeg, dp},
        {4'hF, 7'h7F, 1'b1});
    digit_en = 4'hF;
    lz_blank = 1'b0;

    // load exactly on the wrap cycle
    n = 0;
    while ((e + 1) % NR != 0 && n < 40) begin
      cyc();
      n++;
    end
    value = 16'h5A5A;
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    chk("wrapload_fd", frame_done, 1'b1);
    chk("wrapload_d0", outSeg, 7'b0001000);

    // reset mid-frame with a pending load; loads ignored in reset
    wait_slot(1);
    value = 16'h9999;
    load = 1'b1;
    cyc();
    value = 16'h7777;
    reset = 1'b0;
    cyc();
    cyc();
    load = 1'b0;
    reset = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < N; d++) begin
        wait_slot(d);
        chk("post_rst", outSeg, 7'b1000000);
      end

    // randomized traffic against the model
    repeat (1500) begin
      value = ($urandom_range(0, 3) == 0) ?
              16'($urandom_range(0, 255)) :
              16'($urandom);
      dp_in = 4'($urandom);
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0)
        digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0)
        lz_blank = 1'($urandom);
      reset = ($urandom_range(0, 399) != 0);
      cyc();
    end
    reset = 1'b1;
    load = 1'b0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
